// File: rtl/if_fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package if_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] ZEROWORD         = 32'h0000_0000;
  localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
  localparam logic [2:0]  IFETCH_ARPROT    = 3'b100;

  typedef enum logic {
    FS_ADDR = 1'b0,
    FS_DATA = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch over AXI-Lite: one outstanding read, AR->R->slot in 2 cycles (1 instr / 2 cycles peak).
// Downstream stall holds the output slot and withholds m_rready; redirects drain any in-flight beat.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid,
  output logic              fetch_err,
  output logic              m_arvalid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  output logic              m_rready
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] redirect_pc;
  logic              discard;
  logic              r_hs;
  logic              consume;
  logic [ADDR_W-1:0] target_al;

  // pc only moves on an R handshake, so the AR address stays stable until accepted.
  assign m_araddr  = pc;
  assign m_arprot  = IFETCH_ARPROT;
  assign r_hs      = m_rvalid & m_rready;
  assign consume   = if_valid & ~stall;
  assign target_al = branch_target & ALIGN_MASK;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FS_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    case (state_q)
      FS_ADDR: begin
        m_arvalid = rst;
        if (m_arready) state_d = FS_DATA;
      end
      FS_DATA: begin
        m_rready = rst & (discard | ~if_valid | ~stall);
        if (m_rvalid && m_rready) state_d = FS_ADDR;
      end
      default: state_d = FS_ADDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC_AL;
      redirect_pc <= RESET_PC_AL;
      discard     <= 1'b0;
      if_pc       <= '0;
      if_inst     <= DATA_W'(ZEROWORD);
      if_valid    <= 1'b0;
      fetch_err   <= 1'b0;
    end else if (branch_flag) begin
      if_valid <= 1'b0;
      if (r_hs) begin
        // the completing beat is simply dropped; nothing left to drain
        pc      <= target_al;
        discard <= 1'b0;
      end else begin
        redirect_pc <= target_al;
        discard     <= 1'b1;
      end
    end else if (r_hs && discard) begin
      pc      <= redirect_pc;
      discard <= 1'b0;
      if (consume) if_valid <= 1'b0;
    end else if (r_hs) begin
      if_pc    <= pc;
      if_valid <= 1'b1;
      pc       <= pc + ADDR_W'(4);
      if (m_rresp != AXI_RESP_OKAY) begin
        fetch_err <= 1'b1;
        if_inst   <= DATA_W'(ZEROWORD);
      end else begin
        if_inst <= m_rdata;
      end
    end else if (consume) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage: owns the PC and fetches one instruction per transaction over an AXI-Lite read-only master port.
- Presents pc/instruction pairs, qualified by a valid flag, to the IF/ID pipeline register directly downstream.
- Honours a downstream stall and redirects on branch/jump from later stages.
- Single outstanding transaction; in-order.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- ADDR_W, 32, PC/ARADDR width (matches INST_ADDR_BUS).
- DATA_W, 32, instruction/RDATA width (matches INST_DATA_BUS).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted = 0).
- stall  in  1  downstream cannot accept this cycle.
- branch_flag  in  1  one-cycle redirect request.
- branch_target  in  ADDR_W  redirect PC, valid with branch_flag.
- if_pc  out  ADDR_W  PC of delivered instruction.
- if_inst  out  DATA_W  delivered instruction.
- if_valid  out  1  if_pc/if_inst hold a live instruction.
- fetch_err  out  1  sticky: RRESP != OKAY seen.
- m_arvalid  out  1  AXI-Lite AR valid.
- m_araddr  out  ADDR_W  AXI-Lite AR address, {pc[31:2],2'b00}.
- m_arprot  out  3  constant 3'b100 (instruction access).
- m_arready  in  1  AXI-Lite AR ready.
- m_rvalid  in  1  AXI-Lite R valid.
- m_rdata  in  DATA_W  AXI-Lite R data.
- m_rresp  in  2  AXI-Lite R response.
- m_rready  out  1  AXI-Lite R ready.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=ADDR, discard=0, if_pc=0, if_inst=0 (ZEROWORD), if_valid=0, fetch_err=0; m_arvalid, m_rready=0 while rst=0.
- States: ADDR (m_arvalid=1, m_araddr stable until m_arvalid&m_arready) -> DATA on AR handshake. DATA (m_rready asserted per rule below) -> ADDR on R handshake. No idle state; fetch runs continuously.
- First m_arvalid rises in first cycle after rst deasserts, with m_araddr=RESET_PC.
- m_rready = discard | !if_valid | !stall (output slot empty or being consumed this cycle).
- Consumption: instruction accepted by IF/ID in any cycle with if_valid=1 and stall=0. While if_valid=1 and stall=1, if_pc/if_inst/if_valid hold.
- R handshake, discard=0: if_pc<=pc, if_inst<=m_rdata, if_valid<=1, pc<=pc+4 (wraps mod 2^ADDR_W). Else if slot consumed this cycle: if_valid<=0.
- Latency: AR accepted cycle N, R in cycle N+1 -> if_valid in N+2; next AR in N+2. Peak throughput 1 instr / 2 cycles.
- Redirect (branch_flag=1), highest priority:
  - pc<=branch_target.
  - if_valid<=0 (slot flushed, even if stall=1).
  - If in ADDR or DATA with a transaction not yet completed this cycle, discard<=1: AR is still completed unchanged (AXI stability), response drained and dropped, then ADDR with new pc.
  - Same-cycle R handshake: data dropped, discard not set.
  - Repeat redirect while discard=1: latest target wins, still one drain.
- Discarded beat: clears discard; no pc increment; no output update.
- m_rresp != 2'b00 on a non-discarded beat: fetch_err<=1 (sticky until reset); if_inst<=ZEROWORD, if_valid<=1, pc advances normally.
- branch_target[1:0] ignored (word-aligned fetch).

Decomposition:
- Shared package/define header: RESET_PC default, ZEROWORD, AXI_RESP_OKAY=2'b00, IFETCH_ARPROT=3'b100, state encodings FS_ADDR/FS_DATA.
- Single module; no sub-module warranted (AR/R control and PC logic share state).

Test Plan:
- Reset release, slave with zero-wait AR and R next cycle, rdata=32'h2408_0001 -> araddr BFC00000 then BFC00004; if_valid every 2nd cycle, if_pc=BFC00000 with if_inst=24080001.
- stall=1 for 5 cycles while if_valid=1 -> if_pc/if_inst stable, m_rready=0, next R held by slave; stall=0 -> next instr delivered following cycle, none lost or duplicated.
- branch_flag with target 8000_0100 while in DATA -> in-flight beat dropped, if_valid=0, next araddr=80000100, delivered if_pc=80000100.
- branch_flag in same cycle as m_arvalid&!m_arready (slave delays 3 cycles) -> araddr held at old value until accepted, response discarded, then fetch at target.
- m_rresp=2'b10 on pc BFC00008 -> fetch_err=1 sticky, if_inst=0, following fetch BFC0000C normal.
- rst asserted mid-DATA -> outputs to reset values immediately (asynchronous); after release fetch restarts at BFC00000.
